// File: rtl/hw_manager_gen2_pkg.sv
// Shared state encodings, status codes and status_word layout for the
// second-generation hardware sequencing and fault manager.
package hw_manager_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd1,
    ST_POWERON   = 4'd2,
    ST_START_DMA = 4'd3,
    ST_START_SPI = 4'd4,
    ST_RUNNING   = 4'd5,
    ST_STOPPING  = 4'd6,
    ST_HALTED    = 4'd7
  } state_e;

  localparam int CODE_W = 25;

  localparam logic [CODE_W-1:0] CODE_OK                   = 25'd1;
  localparam logic [CODE_W-1:0] CODE_PS_SHUTDOWN          = 25'd2;
  localparam logic [CODE_W-1:0] CODE_DAC_BUF_FILL_TIMEOUT = 25'd3;
  localparam logic [CODE_W-1:0] CODE_SPI_START_TIMEOUT    = 25'd4;
  localparam logic [CODE_W-1:0] CODE_SHUTDOWN_SENSE       = 25'd6;
  localparam logic [CODE_W-1:0] CODE_EXT_SHUTDOWN         = 25'd7;
  localparam logic [CODE_W-1:0] CODE_BOARD_FAULT_BASE     = 25'd8;

  localparam int SW_STATE_LSB = 0;
  localparam int SW_STATE_W   = 4;
  localparam int SW_CODE_LSB  = 4;
  localparam int SW_BOARD_LSB = 29;
  localparam int SW_BOARD_W   = 3;

  typedef struct packed {
    logic              hit;
    logic [CODE_W-1:0] code;
    logic [2:0]        board;
  } fault_t;

  // Hard faults in priority order: PS disable, sensed shutdown, external shutdown.
  function automatic fault_t hard_fault(input logic       sys_en,
                                        input logic       sense,
                                        input logic [2:0] sense_num,
                                        input logic       ext);
    fault_t f;
    f.hit   = !sys_en || sense || ext;
    f.board = '0;
    if (!sys_en) begin
      f.code = CODE_PS_SHUTDOWN;
    end else if (sense) begin
      f.code  = CODE_SHUTDOWN_SENSE;
      f.board = sense_num;
    end else if (ext) begin
      f.code = CODE_EXT_SHUTDOWN;
    end else begin
      f.code = CODE_OK;
    end
    return f;
  endfunction

endpackage

// File: rtl/hw_manager_gen2_if.sv
// Control/status bundle between the PS-side sequencer environment and the
// hardware manager.
interface hw_manager_gen2_if #(
  parameter int NUM_BOARDS       = 8,
  parameter int NUM_BOARD_FAULTS = 12
);
  logic                                   sys_en;
  logic                                   dac_buf_full;
  logic                                   spi_running;
  logic                                   ext_shutdown;
  logic                                   shutdown_sense;
  logic [2:0]                             sense_num;
  logic [NUM_BOARDS*NUM_BOARD_FAULTS-1:0] board_faults;
  logic [NUM_BOARD_FAULTS-1:0]            fault_en;

  logic        sys_rst;
  logic        dma_en;
  logic        spi_en;
  logic        trig_en;
  logic        shutdown_force;
  logic        n_shutdown_rst;
  logic        stop_timeout;
  logic [31:0] status_word;
  logic        ps_interrupt;

  modport master (
    output sys_en, dac_buf_full, spi_running, ext_shutdown, shutdown_sense,
           sense_num, board_faults, fault_en,
    input  sys_rst, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst,
           stop_timeout, status_word, ps_interrupt
  );

  modport slave (
    input  sys_en, dac_buf_full, spi_running, ext_shutdown, shutdown_sense,
           sense_num, board_faults, fault_en,
    output sys_rst, dma_en, spi_en, trig_en, shutdown_force, n_shutdown_rst,
           stop_timeout, status_word, ps_interrupt
  );
endinterface

// File: rtl/hw_manager_gen2_fault_select.sv
// Masked two-level priority encoder over the flattened board fault bus:
// lowest enabled class wins, then the lowest board within that class.
module hw_fault_select #(
  parameter int NUM_BOARDS       = 8,
  parameter int NUM_BOARD_FAULTS = 12
) (
  input  logic [NUM_BOARDS*NUM_BOARD_FAULTS-1:0] faults_i,
  input  logic [NUM_BOARD_FAULTS-1:0]            en_i,
  output logic                                   any_fault_o,
  output logic [3:0]                             class_o,
  output logic [2:0]                             board_o
);

  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    any_fault_o = 1'b0;
    class_o     = '0;
    board_o     = '0;
    for (int k = NUM_BOARD_FAULTS - 1; k >= 0; k--) begin
      if (en_i[k] && (|faults_i[k*NUM_BOARDS +: NUM_BOARDS])) begin
        any_fault_o = 1'b1;
        class_o     = 4'(k);
        board_o     = '0;
        for (int b = NUM_BOARDS - 1; b >= 0; b--) begin
          if (faults_i[k*NUM_BOARDS + b]) board_o = 3'(b);
        end
      end
    end
  end

endmodule

// File: rtl/hw_manager_gen2.sv
// Power-up sequencer and first-fault latching supervisor for the LCB shim
// boards: POWERON -> DMA -> SPI -> RUNNING, with a controlled SPI stop.
module hw_manager_gen2
  import hw_manager_pkg::*;
#(
  parameter int NUM_BOARDS       = 8,
  parameter int NUM_BOARD_FAULTS = 12,
  parameter int POWERON_WAIT     = 250000000,
  parameter int BUF_LOAD_WAIT    = 250000000,
  parameter int SPI_START_WAIT   = 250000000,
  parameter int SPI_STOP_WAIT    = 250000000
) (
  input logic              clk,
  input logic              n_rst,
  hw_manager_gen2_if.slave bus
);

  state_e            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic              sys_rst_q, sys_rst_d;
  logic              dma_en_q, dma_en_d;
  logic              spi_en_q, spi_en_d;
  logic              trig_en_q, trig_en_d;
  logic              sd_force_q, sd_force_d;
  logic              n_sd_rst_q, n_sd_rst_d;
  logic              stop_to_q, stop_to_d;
  logic              irq_q, irq_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [2:0]        board_q, board_d;

  logic              bf_any;
  logic [3:0]        bf_class;
  logic [2:0]        bf_board;
  fault_t            hf;
  logic [31:0]       wait_lim;
  logic              timeout;
  logic              go_stop, go_halt;
  logic [CODE_W-1:0] new_code;
  logic [2:0]        new_board;

  hw_fault_select #(
    .NUM_BOARDS      (NUM_BOARDS),
    .NUM_BOARD_FAULTS(NUM_BOARD_FAULTS)
  ) u_fault_select (
    .faults_i   (bus.board_faults),
    .en_i       (bus.fault_en),
    .any_fault_o(bf_any),
    .class_o    (bf_class),
    .board_o    (bf_board)
  );

  assign hf = hard_fault(bus.sys_en, bus.shutdown_sense, bus.sense_num, bus.ext_shutdown);

  always_comb begin
    case (state_q)
      ST_POWERON:   wait_lim = 32'(POWERON_WAIT);
      ST_START_DMA: wait_lim = 32'(BUF_LOAD_WAIT);
      ST_START_SPI: wait_lim = 32'(SPI_START_WAIT);
      ST_STOPPING:  wait_lim = 32'(SPI_STOP_WAIT);
      default:      wait_lim = '1;
    endcase
    timeout = (timer_q >= wait_lim);
  end

  // Fault checks come first in every supervised state so they beat success.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 32'd1;
    sys_rst_d  = sys_rst_q;
    dma_en_d   = dma_en_q;
    spi_en_d   = spi_en_q;
    trig_en_d  = trig_en_q;
    sd_force_d = sd_force_q;
    n_sd_rst_d = n_sd_rst_q;
    stop_to_d  = stop_to_q;
    irq_d      = 1'b0;
    go_stop    = 1'b0;
    go_halt    = 1'b0;
    new_code   = code_q;
    new_board  = board_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.sys_en) begin
          state_d    = ST_POWERON;
          sys_rst_d  = 1'b0;
          sd_force_d = 1'b0;
          n_sd_rst_d = 1'b0;
        end
      end
      ST_POWERON: begin
        if (hf.hit) begin
          go_halt   = 1'b1;
          new_code  = hf.code;
          new_board = hf.board;
        end else if (timeout) begin
          state_d    = ST_START_DMA;
          n_sd_rst_d = 1'b1;
          dma_en_d   = 1'b1;
        end
      end
      ST_START_DMA: begin
        if (hf.hit) begin
          go_stop   = 1'b1;
          new_code  = hf.code;
          new_board = hf.board;
        end else if (bus.dac_buf_full) begin
          state_d  = ST_START_SPI;
          spi_en_d = 1'b1;
        end else if (timeout) begin
          go_halt   = 1'b1;
          new_code  = CODE_DAC_BUF_FILL_TIMEOUT;
          new_board = '0;
        end
      end
      ST_START_SPI: begin
        if (hf.hit) begin
          go_stop   = 1'b1;
          new_code  = hf.code;
          new_board = hf.board;
        end else if (bus.spi_running) begin
          state_d   = ST_RUNNING;
          trig_en_d = 1'b1;
          irq_d     = 1'b1;
        end else if (timeout) begin
          go_stop   = 1'b1;
          new_code  = CODE_SPI_START_TIMEOUT;
          new_board = '0;
        end
      end
      ST_RUNNING: begin
        if (hf.hit) begin
          go_stop   = 1'b1;
          new_code  = hf.code;
          new_board = hf.board;
        end else if (bf_any) begin
          go_stop   = 1'b1;
          new_code  = CODE_BOARD_FAULT_BASE + CODE_W'(bf_class);
          new_board = bf_board;
        end
      end
      ST_STOPPING: begin
        if (!bus.spi_running) begin
          go_halt = 1'b1;
        end else if (timeout) begin
          go_halt   = 1'b1;
          stop_to_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (!bus.sys_en) begin
          state_d   = ST_IDLE;
          new_code  = CODE_OK;
          new_board = '0;
          stop_to_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    code_d  = new_code;
    board_d = new_board;

    if (go_stop) begin
      state_d   = ST_STOPPING;
      dma_en_d  = 1'b0;
      spi_en_d  = 1'b0;
      trig_en_d = 1'b0;
      if ((new_code == CODE_SHUTDOWN_SENSE) || (new_code == CODE_EXT_SHUTDOWN))
        sd_force_d = 1'b1;
    end

    if (go_halt) begin
      state_d    = ST_HALTED;
      sys_rst_d  = 1'b1;
      sd_force_d = 1'b1;
      dma_en_d   = 1'b0;
      spi_en_d   = 1'b0;
      trig_en_d  = 1'b0;
      irq_d      = 1'b1;
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      sys_rst_q  <= 1'b1;
      dma_en_q   <= 1'b0;
      spi_en_q   <= 1'b0;
      trig_en_q  <= 1'b0;
      sd_force_q <= 1'b1;
      n_sd_rst_q <= 1'b1;
      stop_to_q  <= 1'b0;
      irq_q      <= 1'b0;
      code_q     <= CODE_OK;
      board_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sys_rst_q  <= sys_rst_d;
      dma_en_q   <= dma_en_d;
      spi_en_q   <= spi_en_d;
      trig_en_q  <= trig_en_d;
      sd_force_q <= sd_force_d;
      n_sd_rst_q <= n_sd_rst_d;
      stop_to_q  <= stop_to_d;
      irq_q      <= irq_d;
      code_q     <= code_d;
      board_q    <= board_d;
    end
  end

  assign bus.sys_rst        = sys_rst_q;
  assign bus.dma_en         = dma_en_q;
  assign bus.spi_en         = spi_en_q;
  assign bus.trig_en        = trig_en_q;
  assign bus.shutdown_force = sd_force_q;
  assign bus.n_shutdown_rst = n_sd_rst_q;
  assign bus.stop_timeout   = stop_to_q;
  assign bus.ps_interrupt   = irq_q;

  always_comb begin
    bus.status_word = '0;
    bus.status_word[SW_STATE_LSB +: SW_STATE_W] = state_q;
    bus.status_word[SW_CODE_LSB  +: CODE_W]     = code_q;
    bus.status_word[SW_BOARD_LSB +: SW_BOARD_W] = board_q;
  end

endmodule

// File: doc/hw_manager_gen2.md
Name: hw_manager_gen2

Overview:
Second-generation hardware sequencing and fault manager for the LCB shim system. It powers up the shim boards and starts DMA, then SPI, then triggers, supervising each step. Per-board faults arrive on one parametrised, flattened bus with a runtime enable mask. A new controlled-stop phase waits for the SPI subsystem to go idle before the system is reset.

Parameters:
NUM_BOARDS, 8, number of shim boards; legal range 1..8.
NUM_BOARD_FAULTS, 12, number of per-board fault classes; legal range 1..16.
POWERON_WAIT, 250000000, cycles spent in POWERON.
BUF_LOAD_WAIT, 250000000, DAC buffer fill timeout.
SPI_START_WAIT, 250000000, SPI start timeout.
SPI_STOP_WAIT, 250000000, SPI stop timeout.

Ports:
clk  in  1  system clock.
n_rst  in  1  reset, asynchronous, active-low.
sys_en  in  1  PS system enable.
dac_buf_full  in  1  DAC buffer full.
spi_running  in  1  SPI subsystem running.
ext_shutdown  in  1  external shutdown.
shutdown_sense  in  1  hardware shutdown sensed.
sense_num  in  3  board that tripped shutdown_sense.
board_faults  in  NUM_BOARDS*NUM_BOARD_FAULTS  fault class k of board b is at bit k*NUM_BOARDS+b.
fault_en  in  NUM_BOARD_FAULTS  per-class enable; 0 ignores that class.
sys_rst  out  1  system reset.
dma_en  out  1  DMA enable.
spi_en  out  1  SPI enable.
trig_en  out  1  trigger enable.
shutdown_force  out  1  force hardware shutdown.
n_shutdown_rst  out  1  shutdown latch reset, active-low.
stop_timeout  out  1  sticky flag: SPI failed to stop in time.
status_word  out  32  {board[2:0], status_code[24:0], state[3:0]}.
ps_interrupt  out  1  one-cycle interrupt pulse.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset n_rst.
- Reset values: state=IDLE, timer=0, sys_rst=1, shutdown_force=1, n_shutdown_rst=1, dma_en=spi_en=trig_en=0, stop_timeout=0, status_code=OK(1), board=0, ps_interrupt=0.
- State encodings: IDLE=1, POWERON=2, START_DMA=3, START_SPI=4, RUNNING=5, STOPPING=6, HALTED=7.
- Timer: 32-bit. Cleared on every state change and incremented otherwise. A timeout fires in the cycle where timer>=WAIT, so a state exits WAIT+1 cycles after entry.
- IDLE: when sys_en=1, go to POWERON; sys_rst=0, shutdown_force=0, n_shutdown_rst=0.
- POWERON: on timeout, go to START_DMA; n_shutdown_rst=1, dma_en=1.
- START_DMA:
  - Priority: hard fault > dac_buf_full > timeout.
  - dac_buf_full: go to START_SPI with spi_en=1.
  - Timeout: go to HALTED, code 3.
- START_SPI:
  - Priority: hard fault > spi_running > timeout.
  - spi_running: go to RUNNING, trig_en=1, pulse ps_interrupt.
  - Timeout: go to STOPPING, code 4.
- Hard fault: sys_en=0 (code 2), shutdown_sense (code 6), or ext_shutdown (code 7), checked in that priority order.
- Hard fault in POWERON: go directly to HALTED with the corresponding code.
- Hard fault in START_DMA or START_SPI: go to STOPPING with the corresponding code.
- RUNNING: on any hard fault or enabled board fault, go to STOPPING.
  - Board fault candidates are board_faults bits with fault_en[k]=1.
  - Priority order: hard faults, then board classes with the lowest k first, then the lowest board b within a class.
  - Board fault code = 8+k.
  - board field = b for board faults, sense_num for shutdown_sense, 0 otherwise.
- Entering STOPPING: trig_en=0, spi_en=0, dma_en=0 in the same cycle; shutdown_force=1 immediately for codes 6 and 7 only.
- STOPPING:
  - spi_running=0: go to HALTED.
  - Timeout: go to HALTED with stop_timeout=1.
  - New faults arriving here are ignored.
- Entering HALTED: sys_rst=1, shutdown_force=1, dma_en=spi_en=trig_en=0; pulse ps_interrupt for exactly one cycle.
- HALTED: when sys_en=0, go to IDLE; status_code=OK, board=0, stop_timeout=0.
- First-fault latching: only the first cause is latched. The code and board are written once on the transition out of the supervised state.
- Simultaneous events: the fault check always precedes success conditions in the same cycle.
- Undriven inputs: bits of board_faults and fault_en beyond the parameter widths do not exist. The board field is zero-extended when NUM_BOARDS<8.
- Reset mid-sequence: all outputs return to reset values asynchronously, with no pulse.

Decomposition:
- hw_manager_pkg holds: the state localparams, status codes (OK=1, PS_SHUTDOWN=2, DAC_BUF_FILL_TIMEOUT=3, SPI_START_TIMEOUT=4, SHUTDOWN_SENSE=6, EXT_SHUTDOWN=7, BOARD_FAULT_BASE=8), and the status_word field offsets.
- One sub-module, hw_fault_select: combinational masked two-level priority encoder. Outputs any_fault, class[3:0] and board[2:0]; parametrised by NUM_BOARDS and NUM_BOARD_FAULTS.

Test Plan:
Bench parameters: NUM_BOARDS=4, NUM_BOARD_FAULTS=12, all WAITs=8, fault_en=all ones unless stated.
- Nominal start: sys_en=1; dac_buf_full at cycle 3 of START_DMA; spi_running 2 cycles later -> state RUNNING, trig_en=1, single ps_interrupt pulse, status_word=0x00000015.
- Buffer timeout: dac_buf_full held 0 -> HALTED 9 cycles after entering START_DMA, code 3, ps_interrupt pulse, sys_rst=1.
- Multi-fault priority: in RUNNING, set bits class2/board3 and class1/board2 together -> STOPPING then HALTED; code 9, board 2. Repeat with fault_en[1]=0 -> code 10, board 3.
- Stop timeout: fault in RUNNING with spi_running held 1 -> HALTED 9 cycles after STOPPING entry; stop_timeout=1; later faults don't change the code.
- Hard-fault precedence: shutdown_sense=1, sense_num=5, and spi_running rising in the same START_SPI cycle -> STOPPING, code 6, board 5, shutdown_force=1 immediately.
- Reset and exit: deassert n_rst mid-RUNNING -> all reset values immediately. Separately, sys_en=0 in HALTED -> IDLE with status code OK.
